// File: rtl/uart.sv
// uart: full-duplex 8N1 UART; RX and TX each run off a 4x-oversample tick.
// Optional UART_RX_SYNC_EN: 2-flop synchronizer on rx ahead of the RX FSM.
module uart #(
   parameter int unsigned baud_rate    = 9600,
   parameter int unsigned sys_clk_freq = 12000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       tx,
   input  logic       transmit,
   input  logic [7:0] tx_byte,
   output logic       received,
   output logic [7:0] rx_byte,
   output logic       is_receiving,
   output logic       is_transmitting,
   output logic       recv_error
);

   localparam int unsigned CLOCK_DIVIDE = sys_clk_freq / (baud_rate * 4);
   localparam int unsigned TIMER_W      = $clog2(CLOCK_DIVIDE + 1);
   localparam int unsigned CNT_W        = 4;
   localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(CLOCK_DIVIDE);

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_CHECK_START,
      RX_READ_BITS,
      RX_CHECK_STOP,
      RX_DELAY_RESTART,
      RX_ERROR,
      RX_RECEIVED
   } rx_state_e;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_SENDING,
      TX_DELAY_RESTART
   } tx_state_e;

   logic rx_s;

`ifdef UART_RX_SYNC_EN
   logic [1:0] rx_sync_q;

   // Resets to idle-high so a held reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rx_sync_q <= 2'b11;
      else      rx_sync_q <= {rx_sync_q[0], rx};
   end

   assign rx_s = rx_sync_q[1];
`else
   assign rx_s = rx;
`endif

   // ---------------- receiver ----------------
   rx_state_e          rx_state_q, rx_state_d;
   logic [TIMER_W-1:0] rx_timer_q, rx_timer_d;
   logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
   logic [CNT_W-1:0]   rx_bits_q, rx_bits_d;
   logic [7:0]         rx_data_q, rx_data_d;
   logic [7:0]         rx_byte_q;
   logic               received_q, recv_error_q, is_receiving_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_state_q     <= RX_IDLE;
         rx_timer_q     <= '0;
         rx_cnt_q       <= '0;
         rx_bits_q      <= '0;
         rx_data_q      <= '0;
         rx_byte_q      <= '0;
         received_q     <= 1'b0;
         recv_error_q   <= 1'b0;
         is_receiving_q <= 1'b0;
      end else begin
         rx_state_q     <= rx_state_d;
         rx_timer_q     <= rx_timer_d;
         rx_cnt_q       <= rx_cnt_d;
         rx_bits_q      <= rx_bits_d;
         rx_data_q      <= rx_data_d;
         received_q     <= (rx_state_d == RX_RECEIVED);
         recv_error_q   <= (rx_state_d == RX_ERROR);
         is_receiving_q <= (rx_state_d != RX_IDLE);
         if (rx_state_d == RX_RECEIVED) rx_byte_q <= rx_data_q;
      end
   end

   // Quarter-bit timer free-runs; FSM decisions use the post-tick countdown.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_timer_d = rx_timer_q - TIMER_W'(1);
      rx_cnt_d   = rx_cnt_q;
      rx_bits_d  = rx_bits_q;
      rx_data_d  = rx_data_q;
      if (rx_timer_d == '0) begin
         rx_timer_d = TIMER_RELOAD;
         rx_cnt_d   = rx_cnt_q - CNT_W'(1);
      end
      case (rx_state_q)
         RX_IDLE: begin
            if (!rx_s) begin
               rx_timer_d = TIMER_RELOAD;
               rx_cnt_d   = CNT_W'(2);
               rx_state_d = RX_CHECK_START;
            end
         end
         RX_CHECK_START: begin
            if (rx_cnt_d == '0) begin
               if (!rx_s) begin
                  rx_cnt_d   = CNT_W'(4);
                  rx_bits_d  = CNT_W'(8);
                  rx_state_d = RX_READ_BITS;
               end else begin
                  rx_state_d = RX_ERROR;
               end
            end
         end
         RX_READ_BITS: begin
            if (rx_cnt_d == '0) begin
               rx_data_d = {rx_s, rx_data_q[7:1]};
               rx_cnt_d  = CNT_W'(4);
               rx_bits_d = rx_bits_q - CNT_W'(1);
               if (rx_bits_q == CNT_W'(1)) rx_state_d = RX_CHECK_STOP;
            end
         end
         RX_CHECK_STOP: begin
            if (rx_cnt_d == '0) rx_state_d = rx_s ? RX_RECEIVED : RX_ERROR;
         end
         RX_ERROR: begin
            rx_cnt_d   = CNT_W'(8);
            rx_state_d = RX_DELAY_RESTART;
         end
         RX_DELAY_RESTART: begin
            if (rx_cnt_d == '0) rx_state_d = RX_IDLE;
         end
         RX_RECEIVED: begin
            rx_state_d = RX_IDLE;
         end
         default: begin
            rx_state_d = RX_IDLE;
         end
      endcase
   end

   // ---------------- transmitter ----------------
   tx_state_e          tx_state_q, tx_state_d;
   logic [TIMER_W-1:0] tx_timer_q, tx_timer_d;
   logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
   logic [CNT_W-1:0]   tx_bits_q, tx_bits_d;
   logic [8:0]         tx_data_q, tx_data_d;
   logic               tx_q, tx_d;
   logic               is_transmitting_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_q        <= TX_IDLE;
         tx_timer_q        <= '0;
         tx_cnt_q          <= '0;
         tx_bits_q         <= '0;
         tx_data_q         <= '0;
         tx_q              <= 1'b1;
         is_transmitting_q <= 1'b0;
      end else begin
         tx_state_q        <= tx_state_d;
         tx_timer_q        <= tx_timer_d;
         tx_cnt_q          <= tx_cnt_d;
         tx_bits_q         <= tx_bits_d;
         tx_data_q         <= tx_data_d;
         tx_q              <= tx_d;
         is_transmitting_q <= (tx_state_d != TX_IDLE);
      end
   end

   // Shift register holds data plus stop bit; start bit is driven on accept.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_timer_d = tx_timer_q - TIMER_W'(1);
      tx_cnt_d   = tx_cnt_q;
      tx_bits_d  = tx_bits_q;
      tx_data_d  = tx_data_q;
      tx_d       = tx_q;
      if (tx_timer_d == '0) begin
         tx_timer_d = TIMER_RELOAD;
         tx_cnt_d   = tx_cnt_q - CNT_W'(1);
      end
      case (tx_state_q)
         TX_IDLE: begin
            if (transmit) begin
               tx_data_d  = {1'b1, tx_byte};
               tx_timer_d = TIMER_RELOAD;
               tx_cnt_d   = CNT_W'(4);
               tx_bits_d  = CNT_W'(9);
               tx_d       = 1'b0;
               tx_state_d = TX_SENDING;
            end
         end
         TX_SENDING: begin
            if (tx_cnt_d == '0) begin
               if (tx_bits_q != '0) begin
                  tx_d      = tx_data_q[0];
                  tx_data_d = {1'b0, tx_data_q[8:1]};
                  tx_cnt_d  = CNT_W'(4);
                  tx_bits_d = tx_bits_q - CNT_W'(1);
               end else begin
                  tx_d       = 1'b1;
                  tx_cnt_d   = CNT_W'(4);
                  tx_state_d = TX_DELAY_RESTART;
               end
            end
         end
         TX_DELAY_RESTART: begin
            if (tx_cnt_d == '0) tx_state_d = TX_IDLE;
         end
         default: begin
            tx_state_d = TX_IDLE;
         end
      endcase
   end

   assign tx              = tx_q;
   assign received        = received_q;
   assign rx_byte         = rx_byte_q;
   assign is_receiving    = is_receiving_q;
   assign is_transmitting = is_transmitting_q;
   assign recv_error      = recv_error_q;

endmodule

// File: tb/tb_uart.sv
// tb_uart: scoreboard bench for uart at CLOCK_DIVIDE=4 (16 clk per bit).
module tb_uart;

   localparam int CLK_PER_BIT = 16;

   logic       clk      = 1'b0;
   logic       rst      = 1'b0;
   logic       rx       = 1'b1;
   logic       transmit = 1'b0;
   logic [7:0] tx_byte  = 8'h00;
   logic       tx, received, is_receiving, is_transmitting, recv_error;
   logic [7:0] rx_byte;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] exp_rx[$];
   logic       exp_tx[$];

   uart #(.baud_rate(62500), .sys_clk_freq(1000000)) dut (
      .clk(clk), .rst(rst), .rx(rx), .tx(tx), .transmit(transmit), .tx_byte(tx_byte),
      .received(received), .rx_byte(rx_byte), .is_receiving(is_receiving),
      .is_transmitting(is_transmitting), .recv_error(recv_error)
   );

   always #5 clk = ~clk;

   // Drive one serial frame on rx, starting at a falling edge.
   task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = fr[i];
         repeat (CLK_PER_BIT) @(negedge clk);
      end
   endtask

   // Watch a bounded window; pop the scoreboard on every received strobe.
   task automatic watch_rx(input int cycles, output int n_recv, output int n_rerr);
      logic [7:0] e;
      n_recv = 0;
      n_rerr = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (received) begin
            n_recv++;
            n_cmp++;
            if (exp_rx.size() == 0) begin
               n_err++;
               $display("FAIL rx_unexpected: got %02h, required no strobe", rx_byte);
            end else begin
               e = exp_rx.pop_front();
               if (rx_byte !== e) begin
                  n_err++;
                  $display("FAIL rx_byte: got %02h, required %02h", rx_byte, e);
               end
            end
         end
         if (recv_error) n_rerr++;
      end
   endtask

   // Request a byte and check every bit at its first and last clock.
   task automatic tx_frame(input logic [7:0] b);
      logic [9:0] fr;
      logic       e;
      fr = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) exp_tx.push_back(fr[i]);
      tx_byte  = b;
      transmit = 1'b1;
      @(negedge clk);
      transmit = 1'b0;
      n_cmp++;
      if (is_transmitting !== 1'b1) begin
         n_err++;
         $display("FAIL tx_busy_rise byte %02h: got %b, required 1", b, is_transmitting);
      end
      for (int i = 0; i < 10; i++) begin
         e = exp_tx.pop_front();
         n_cmp++;
         if (tx !== e) begin
            n_err++;
            $display("FAIL tx_bit_head byte %02h bit %0d: got %b, required %b", b, i, tx, e);
         end
         repeat (CLK_PER_BIT - 1) @(negedge clk);
         n_cmp++;
         if (tx !== e) begin
            n_err++;
            $display("FAIL tx_bit_tail byte %02h bit %0d: got %b, required %b", b, i, tx, e);
         end
         @(negedge clk);
      end
      repeat (CLK_PER_BIT - 1) @(negedge clk);
      n_cmp++;
      if ({tx, is_transmitting} !== 2'b11) begin
         n_err++;
         $display("FAIL tx_idle_bit byte %02h: got tx=%b busy=%b, required tx=1 busy=1", b, tx, is_transmitting);
      end
      @(negedge clk);
      n_cmp++;
      if ({tx, is_transmitting} !== 2'b10) begin
         n_err++;
         $display("FAIL tx_busy_fall byte %02h: got tx=%b busy=%b, required tx=1 busy=0", b, tx, is_transmitting);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({tx, received, recv_error, is_receiving, is_transmitting} !== 5'b10000) begin
         n_err++;
         $display("FAIL reset_flags: got %b, required 10000",
                  {tx, received, recv_error, is_receiving, is_transmitting});
      end
      n_cmp++;
      if (rx_byte !== 8'h00) begin
         n_err++;
         $display("FAIL reset_rx_byte: got %02h, required 00", rx_byte);
      end
      rst = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++;
      if ({tx, received, recv_error, is_receiving, is_transmitting} !== 5'b10000) begin
         n_err++;
         $display("FAIL post_reset_flags: got %b, required 10000",
                  {tx, received, recv_error, is_receiving, is_transmitting});
      end
   endtask

   task automatic test_tx();
      tx_frame(8'hA5);
      repeat (5) @(negedge clk);
   endtask

   task automatic test_rx();
      int nr, ne;
      exp_rx.push_back(8'h3C);
      fork
         drive_frame(8'h3C, 1'b1);
         watch_rx(200, nr, ne);
      join
      n_cmp++;
      if (nr !== 1 || ne !== 0) begin
         n_err++;
         $display("FAIL rx_strobes: got recv=%0d err=%0d, required recv=1 err=0", nr, ne);
      end
      n_cmp++;
      if ({is_receiving, rx_byte} !== {1'b0, 8'h3C}) begin
         n_err++;
         $display("FAIL rx_after: got busy=%b byte=%02h, required busy=0 byte=3c", is_receiving, rx_byte);
      end
   endtask

   task automatic test_frame_error();
      int nr, ne;
      fork
         begin
            drive_frame(8'h55, 1'b0);
            rx = 1'b1;
         end
         watch_rx(200, nr, ne);
      join
      n_cmp++;
      if (nr !== 0 || ne !== 1) begin
         n_err++;
         $display("FAIL frame_err_strobes: got recv=%0d err=%0d, required recv=0 err=1", nr, ne);
      end
      n_cmp++;
      if (rx_byte !== 8'h3C) begin
         n_err++;
         $display("FAIL frame_err_hold: got %02h, required 3c", rx_byte);
      end
      repeat (40) @(negedge clk);
      exp_rx.push_back(8'h12);
      fork
         drive_frame(8'h12, 1'b1);
         watch_rx(200, nr, ne);
      join
      n_cmp++;
      if (nr !== 1 || ne !== 0 || exp_rx.size() != 0) begin
         n_err++;
         $display("FAIL rx_recover: got recv=%0d err=%0d, required recv=1 err=0", nr, ne);
      end
   endtask

   task automatic test_glitch();
      int nr, ne;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      watch_rx(80, nr, ne);
      n_cmp++;
      if (nr !== 0 || ne !== 1) begin
         n_err++;
         $display("FAIL glitch_strobes: got recv=%0d err=%0d, required recv=0 err=1", nr, ne);
      end
      n_cmp++;
      if ({is_receiving, rx_byte} !== {1'b0, 8'h12}) begin
         n_err++;
         $display("FAIL glitch_after: got busy=%b byte=%02h, required busy=0 byte=12", is_receiving, rx_byte);
      end
   endtask

   task automatic test_reset_mid();
      int nr, ne;
      tx_byte  = 8'h81;
      transmit = 1'b1;
      @(negedge clk);
      transmit = 1'b0;
      rx       = 1'b0;
      repeat (40) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if ({tx, is_transmitting, is_receiving} !== 3'b100) begin
         n_err++;
         $display("FAIL reset_mid_async: got tx=%b busy_tx=%b busy_rx=%b, required 1/0/0",
                  tx, is_transmitting, is_receiving);
      end
      n_cmp++;
      if (rx_byte !== 8'h00) begin
         n_err++;
         $display("FAIL reset_mid_rx_byte: got %02h, required 00", rx_byte);
      end
      rx = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      watch_rx(200, nr, ne);
      n_cmp++;
      if (nr !== 0 || ne !== 0 || tx !== 1'b1 || is_transmitting !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_after: got recv=%0d err=%0d tx=%b busy=%b, required 0 0 1 0",
                  nr, ne, tx, is_transmitting);
      end
   endtask

   task automatic test_overlap();
      int busy_cycles;
      fork
         tx_frame(8'h3A);
         begin
            repeat (40) @(negedge clk);
            tx_byte  = 8'hC5;
            transmit = 1'b1;
            @(negedge clk);
            transmit = 1'b0;
         end
      join
      busy_cycles = 0;
      repeat (40) begin
         @(negedge clk);
         if (is_transmitting || !tx) busy_cycles++;
      end
      n_cmp++;
      if (busy_cycles !== 0) begin
         n_err++;
         $display("FAIL overlap_no_queue: got %0d busy cycles, required 0", busy_cycles);
      end
   endtask

   task automatic test_full_duplex();
      int nr, ne;
      exp_rx.push_back(8'h00);
      fork
         tx_frame(8'hFF);
         drive_frame(8'h00, 1'b1);
         watch_rx(200, nr, ne);
      join
      n_cmp++;
      if (nr !== 1 || ne !== 0 || exp_rx.size() != 0) begin
         n_err++;
         $display("FAIL duplex_rx: got recv=%0d err=%0d, required recv=1 err=0", nr, ne);
      end
   endtask

   initial begin
      test_reset();
      test_tx();
      test_rx();
      test_frame_error();
      test_glitch();
      test_reset_mid();
      test_overlap();
      test_full_duplex();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
